wb_mem_tester: RTL and testbench

Parametrised Wishbone B3 classic-cycle master that exercises a `wb_ram` instance with a full write pass followed by a read-back-and-compare pass. It replaces the free-running counter stimulus at the top level with a real handshaking bus master. It selects one of four data patterns and reports pass/fail, a saturating error count and the first failing address. It runs in the `clk_i` domain alongside the RAM.

---
 rtl/wb_mem_tester.sv | 175 +++++++++++++++++
 tb/tb_wb_mem_tester.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_tester.sv
// Wishbone B3 classic master: writes a pattern across the RAM, then reads it back and
// compares, reporting pass/fail, a saturating error count and the first failing address.
module wb_mem_tester #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [1:0]              mode_i,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic [15:0]             err_count_o,
  output logic [ADDR_WIDTH-1:0]   first_err_addr_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] LfsrSeed32 = 32'h0000_ACE1;
  localparam logic [31:0] LfsrTaps32 = 32'h8020_0003;
  localparam logic [DATA_WIDTH-1:0] LfsrSeed = LfsrSeed32[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] LfsrTaps = LfsrTaps32[31 -: DATA_WIDTH];
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [TmoW-1:0]       TmoLast  = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StWrReq, StWrGap, StRdReq, StRdGap, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   lfsr_q, lfsr_d, lfsr_next;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]   first_q, first_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [DATA_WIDTH-1:0]   pattern, walk;
  logic                    err_event, term, stb;

  assign lfsr_next = {1'b0, lfsr_q[DATA_WIDTH-1:1]} ^ (lfsr_q[0] ? LfsrTaps : '0);
  assign walk      = DATA_WIDTH'(1) << (32'(addr_q) % DATA_WIDTH);

  always_comb begin
    unique case (mode_q)
      2'b00:   pattern = DATA_WIDTH'(addr_q);
      2'b01:   pattern = ~DATA_WIDTH'(addr_q);
      2'b10:   pattern = lfsr_q;
      default: pattern = walk;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    lfsr_d    = lfsr_q;
    tmo_d     = tmo_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_event = 1'b0;
    term      = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d   = StWrReq;
          addr_d    = '0;
          mode_d    = mode_i;
          lfsr_d    = LfsrSeed;
          tmo_d     = '0;
          err_cnt_d = '0;
          first_d   = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end
      end
      StWrReq, StRdReq: begin
        // err wins over a simultaneous ack so the access counts once.
        if (wb_err_i) begin
          err_event = 1'b1;
          term      = 1'b1;
        end else if (wb_ack_i) begin
          term      = 1'b1;
          err_event = (state_q == StRdReq) && (wb_data_i != pattern);
        end else if (tmo_q == TmoLast) begin
          err_event = 1'b1;
          term      = 1'b1;
        end
        if (term) begin
          state_d = (state_q == StWrReq) ? StWrGap : StRdGap;
          lfsr_d  = lfsr_next;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWrGap: begin
        if (addr_q != LastAddr) begin
          addr_d  = addr_q + 1'b1;
          state_d = StWrReq;
        end else begin
          addr_d  = '0;
          lfsr_d  = LfsrSeed;
          state_d = StRdReq;
        end
      end
      StRdGap: begin
        if (addr_q != LastAddr) begin
          addr_d  = addr_q + 1'b1;
          state_d = StRdReq;
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (err_cnt_q == '0);
        end
      end
      default: state_d = StIdle;
    endcase
    if (err_event) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      if (err_cnt_q == '0) first_d = addr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      mode_q    <= '0;
      lfsr_q    <= LfsrSeed;
      tmo_q     <= '0;
      err_cnt_q <= '0;
      first_q   <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      lfsr_q    <= lfsr_d;
      tmo_q     <= tmo_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  // Bus outputs decode registered state only; nothing flows straight from inputs.
  assign stb              = (state_q == StWrReq) || (state_q == StRdReq);
  assign wb_stb_o         = stb;
  assign wb_cyc_o         = stb;
  assign wb_sel_o         = stb ? '1 : '0;
  assign wb_we_o          = (state_q == StWrReq) || (state_q == StWrGap);
  assign wb_addr_o        = addr_q;
  assign wb_data_o        = (state_q == StWrReq) ? pattern : '0;
  assign busy_o           = (state_q != StIdle) && (state_q != StDone);
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_cnt_q;
  assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_wb_mem_tester.sv
// Bench for wb_mem_tester: behavioural Wishbone RAM slave with fault knobs, plus a
// sweep-level reference model for patterns, error counts and first failing address.
module tb_wb_mem_tester;

  localparam int AW = 4;
  localparam int D  = 16;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 0;
  logic          reset_i = 1;
  logic          start_i = 0;
  logic [1:0]    mode_i = 0;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_dout, wb_din;
  logic          wb_we, wb_cyc, wb_stb, wb_ack, wb_err;
  logic [3:0]    wb_sel;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave fault knobs
  int          lat_max = 0;
  int          noack_addr = -1;
  int          corrupt_addr = -1;
  logic [31:0] corrupt_mask = 0;
  int          errw_addr = -1;

  logic [31:0] mem [D];
  logic        ack_r = 0, err_r = 0;
  logic [31:0] rdata = 0;
  int          wcnt = 0;

  int          stb_run = 0, max_run = 0;
  logic [35:0] wq[$];

  always #5 clk = ~clk;

  wb_mem_tester #(.ADDR_WIDTH(AW), .DEPTH(D), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
    .wb_addr_o(wb_addr), .wb_data_o(wb_dout), .wb_data_i(wb_din), .wb_we_o(wb_we),
    .wb_sel_o(wb_sel), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_ack_i(wb_ack),
    .wb_err_i(wb_err), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(err_count), .first_err_addr_o(first_err)
  );

  assign wb_ack = ack_r;
  assign wb_err = err_r;
  assign wb_din = rdata;

  initial for (int i = 0; i < D; i++) mem[i] = 32'hDEAD_0000 + i;

  // Slave: ack after 0..lat_max extra waits, one-cycle pulse, stores even when erroring.
  always @(posedge clk) begin
    if (ack_r || err_r) begin
      ack_r <= 0;
      err_r <= 0;
      wcnt  <= $urandom_range(0, lat_max);
    end else if (wb_stb && !reset_i) begin
      if (int'(wb_addr) == noack_addr) begin
      end else if (wcnt == 0) begin
        ack_r <= 1;
        if (wb_we) begin
          mem[wb_addr] <= wb_dout;
          if (int'(wb_addr) == errw_addr) err_r <= 1;
        end else begin
          rdata <= mem[wb_addr] ^ ((int'(wb_addr) == corrupt_addr) ? corrupt_mask : 32'h0);
        end
      end else begin
        wcnt <= wcnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (wb_stb) begin
      stb_run = stb_run + 1;
      if (stb_run > max_run) max_run = stb_run;
    end else begin
      stb_run = 0;
    end
    if (wb_stb && wb_ack && wb_we) wq.push_back({wb_addr, wb_dout});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [1:0] m, input int a);
    logic [31:0] l;
    case (m)
      2'b00: return 32'(a);
      2'b01: return ~32'(a);
      2'b10: begin
        l = 32'hACE1;
        for (int i = 0; i < a; i++) l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
        return l;
      end
      default: return 32'h1 << (a % 32);
    endcase
  endfunction

  // Errors in bus order: write pass then read pass.
  task automatic model(output int cnt, output int first);
    cnt = 0;
    first = 0;
    for (int pass_no = 0; pass_no < 2; pass_no++)
      for (int a = 0; a < D; a++) begin
        if (a == noack_addr || (pass_no == 0 && a == errw_addr) ||
            (pass_no == 1 && a == corrupt_addr && corrupt_mask != 0)) begin
          if (cnt == 0) first = a;
          cnt++;
        end
      end
  endtask

  task automatic run_sweep(input logic [1:0] m, input bit hold, output int cycles);
    @(negedge clk);
    mode_i  = m;
    start_i = 1;
    wq.delete();
    max_run = 0;
    cycles  = 0;
    do begin
      @(posedge clk);
      #1;
      if (!hold) start_i = 0;
      mode_i = 2'($urandom);
      cycles++;
    end while (!done && cycles < 5000);
    if (!done) check_eq("sweep_timeout", 32'(cycles), 32'(0));
  endtask

  task automatic check_results(input string tag, input logic [1:0] m, input bit chk_wq);
    int cnt, first;
    model(cnt, first);
    check_eq({tag, "_errcnt"}, 32'(err_count), 32'(cnt));
    check_eq({tag, "_first"}, 32'(first_err), 32'(first));
    check_eq({tag, "_pass"}, 32'(pass), 32'(cnt == 0));
    check_eq({tag, "_busy"}, 32'(busy), 32'(0));
    if (chk_wq) begin
      check_eq({tag, "_nwr"}, 32'(wq.size()), 32'(D));
      foreach (wq[i]) begin
        check_eq({tag, "_wa"}, 32'(wq[i][35:32]), 32'(i));
        check_eq({tag, "_wd"}, wq[i][31:0], pat(m, i));
      end
    end
  endtask

  task automatic clear_knobs();
    lat_max = 0; noack_addr = -1; corrupt_addr = -1; corrupt_mask = 0; errw_addr = -1;
  endtask

  initial begin
    int cyc, guard;
    logic [1:0] m;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_stb", 32'(wb_stb), 0);
    check_eq("rst_cyc", 32'(wb_cyc), 0);
    check_eq("rst_busy_done_pass", {29'b0, busy, done, pass}, 0);
    check_eq("rst_errcnt", 32'(err_count), 0);
    check_eq("rst_addr_data", 32'(wb_addr) | wb_dout | 32'(wb_sel) | 32'(wb_we), 0);
    reset_i = 0;

    // Ideal 1-wait RAM, address pattern: 6*D+1 cycles
    clear_knobs();
    run_sweep(2'b00, 0, cyc);
    check_eq("m0_cycles", 32'(cyc), 32'(6 * D + 1));
    check_results("m0", 2'b00, 1);

    // LFSR with bit 3 corrupted at address 5
    corrupt_addr = 5; corrupt_mask = 32'h8;
    run_sweep(2'b10, 0, cyc);
    check_results("m2_corrupt", 2'b10, 1);

    // Never acks address 2: both accesses time out
    clear_knobs();
    noack_addr = 2;
    run_sweep(2'b00, 0, cyc);
    check_eq("tmo_stb_len", 32'(max_run), 32'(TO));
    check_results("tmo", 2'b00, 0);

    // err together with ack on write to address 7
    clear_knobs();
    errw_addr = 7;
    run_sweep(2'b01, 0, cyc);
    check_results("errack", 2'b01, 1);

    // Reset in the middle of the read pass at address 9
    clear_knobs();
    @(negedge clk);
    mode_i = 2'b11;
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    guard = 0;
    while (!(wb_stb && !wb_we && wb_addr == 9) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("rst_mid_reach", 32'(guard < 1000), 1);
    reset_i = 1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_stb", 32'(wb_stb), 0);
    check_eq("rst_mid_busy", 32'(busy), 0);
    check_eq("rst_mid_cnt", 32'(err_count) | 32'(first_err) | 32'(wb_addr), 0);
    reset_i = 0;
    run_sweep(2'b11, 0, cyc);
    check_results("rerun", 2'b11, 1);

    // start_i held high: no restart mid-sweep, immediate restart from DONE
    run_sweep(2'b00, 1, cyc);
    check_eq("hold_cycles", 32'(cyc), 32'(6 * D + 1));
    check_eq("hold_pass", 32'(pass), 1);
    @(posedge clk);
    #1;
    check_eq("hold_restart_busy", 32'(busy), 1);
    check_eq("hold_restart_done", 32'(done), 0);
    check_eq("hold_restart_stb", 32'(wb_stb), 1);
    check_eq("hold_restart_addr", 32'(wb_addr), 0);
    start_i = 0;
    reset_i = 1;
    @(posedge clk);
    #1;
    reset_i = 0;

    // Randomized sweeps
    for (int r = 0; r < 6; r++) begin
      clear_knobs();
      m = 2'($urandom);
      lat_max = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        corrupt_addr = $urandom_range(0, D - 1);
        corrupt_mask = 32'h1 << $urandom_range(0, 31);
      end
      run_sweep(m, 0, cyc);
      check_results("rand", m, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
